// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding, error codes and defaults for the UART command sequencer
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_CHK = 2'd0,
        ERR_LEN = 2'd1,
        ERR_OVF = 2'd2,
        ERR_TMO = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

    // Inter-byte gap limit in clock cycles; one byte time is ten bit times on the line.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned baud,
                                                   input int unsigned bytes);
        return bytes * 10 * (clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// rtl/uart_cmd_sequencer_if.sv - byte strobe input, command handshake and error report bundle
interface uart_cmd_sequencer_if #(
    parameter int MAX_PAYLOAD = 8
);
    logic                     i_rx_done;
    logic [7:0]               i_rx_byte;
    logic                     o_cmd_valid;
    logic                     i_cmd_ready;
    logic [7:0]               o_cmd_opcode;
    logic [7:0]               o_cmd_len;
    logic [8*MAX_PAYLOAD-1:0] o_cmd_payload;
    logic                     o_err;
    logic [1:0]               o_err_code;
    logic                     o_busy;

    modport master (
        input  i_rx_done,
        input  i_rx_byte,
        input  i_cmd_ready,
        output o_cmd_valid,
        output o_cmd_opcode,
        output o_cmd_len,
        output o_cmd_payload,
        output o_err,
        output o_err_code,
        output o_busy
    );

    modport slave (
        output i_rx_done,
        output i_rx_byte,
        output i_cmd_ready,
        input  o_cmd_valid,
        input  o_cmd_opcode,
        input  o_cmd_len,
        input  o_cmd_payload,
        input  o_err,
        input  o_err_code,
        input  o_busy
    );
endinterface

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - loadable down-counter that strobes once LIMIT cycles pass without a reload
module uart_cmd_timeout #(
    parameter int unsigned LIMIT = 8680
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= W'(LIMIT);
        end else if (i_run && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // A reload in the expiry cycle suppresses the strobe, so a late byte still counts.
    assign o_expire = i_run && !i_load && (cnt == W'(1));

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - frame parser (SYNC OPC LEN payload CHK) handing commands over valid/ready
// Optional inter-byte gap timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 25000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int          MAX_PAYLOAD     = 8,
    parameter logic [7:0]  SYNC_BYTE       = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_BYTES   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_cmd_sequencer_if.master bus
);
    localparam logic [7:0]  MAX_LEN   = 8'(MAX_PAYLOAD);
    localparam int unsigned TMO_LIMIT = timeout_cycles(CLOCK_FREQUENCY, BAUD_RATE, TIMEOUT_BYTES);

    state_t     state;
    logic [7:0] opcode;
    logic [7:0] len;
    logic [7:0] count;
    logic [7:0] xor_acc;
    logic [7:0] payload [MAX_PAYLOAD];
    logic       cmd_valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic       tmo_expire;

    logic       rx_done;
    logic [7:0] rx_byte;
    assign rx_done = bus.i_rx_done;
    assign rx_byte = bus.i_rx_byte;

`ifdef UART_CMD_TIMEOUT_EN
    logic tmo_run;
    assign tmo_run = (state == ST_OPC) || (state == ST_LEN) ||
                     (state == ST_PAY) || (state == ST_CHK);

    uart_cmd_timeout #(
        .LIMIT (TMO_LIMIT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (rx_done),
        .i_run    (tmo_run),
        .o_expire (tmo_expire)
    );
`else
    logic [31:0] unused_tmo_limit;
    assign unused_tmo_limit = 32'(TMO_LIMIT);
    assign tmo_expire       = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            opcode    <= '0;
            len       <= '0;
            count     <= '0;
            xor_acc   <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_CHK;
            busy      <= 1'b0;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                payload[k] <= '0;
            end
        end else begin
            err <= 1'b0;
            if (tmo_expire) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= ERR_TMO;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_done && rx_byte == SYNC_BYTE) begin
                            state <= ST_OPC;
                            busy  <= 1'b1;
                            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                                payload[k] <= '0;
                            end
                        end
                    end
                    ST_OPC: begin
                        if (rx_done) begin
                            opcode  <= rx_byte;
                            xor_acc <= rx_byte;
                            state   <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_done) begin
                            len     <= rx_byte;
                            xor_acc <= xor_acc ^ rx_byte;
                            count   <= '0;
                            if (rx_byte > MAX_LEN) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= ERR_LEN;
                            end else if (rx_byte == 8'd0) begin
                                state <= ST_CHK;
                            end else begin
                                state <= ST_PAY;
                            end
                        end
                    end
                    ST_PAY: begin
                        if (rx_done) begin
                            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                                if (count == 8'(k)) payload[k] <= rx_byte;
                            end
                            count   <= count + 8'd1;
                            xor_acc <= xor_acc ^ rx_byte;
                            if (count == len - 8'd1) state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_done) begin
                            if (rx_byte == xor_acc) begin
                                state     <= ST_HOLD;
                                cmd_valid <= 1'b1;
                            end else begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                err_code <= ERR_CHK;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // The held command wins; a byte landing now is lost and reported.
                        if (rx_done) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVF;
                        end
                        if (cmd_valid && bus.i_cmd_ready) begin
                            state     <= ST_IDLE;
                            cmd_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cmd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [8*MAX_PAYLOAD-1:0] payload_flat;
    always_comb begin
        payload_flat = '0;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            payload_flat[8*k +: 8] = payload[k];
        end
    end

    assign bus.o_cmd_valid   = cmd_valid;
    assign bus.o_cmd_opcode  = opcode;
    assign bus.o_cmd_len     = len;
    assign bus.o_cmd_payload = payload_flat;
    assign bus.o_err         = err;
    assign bus.o_err_code    = err_code;
    assign bus.o_busy        = busy;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - directed self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

    localparam int unsigned TMO_CYCLES = 4 * 10 * (25000000 / 115200);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;

    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.MAX_PAYLOAD(8)) bus ();

    uart_cmd_sequencer #(
        .CLOCK_FREQUENCY (25000000),
        .BAUD_RATE       (115200),
        .MAX_PAYLOAD     (8),
        .SYNC_BYTE       (8'hAA),
        .TIMEOUT_BYTES   (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always @(negedge clk) begin
        if (bus.o_err === 1'b1) err_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_done = 1'b1;
        bus.i_rx_byte = b;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    // Bytes are given most-significant first so literals read in wire order.
    task automatic send_bytes(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_byte(v[8*i +: 8]);
        end
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.i_rx_done   = 1'b0;
        bus.i_rx_byte   = 8'h00;
        bus.i_cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.o_cmd_valid); end
        checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_cmd_payload !== 64'h0) begin failures++; $display("FAIL reset_payload: got %h expected 0", bus.o_cmd_payload); end
        checks++; if (bus.o_cmd_opcode !== 8'h00 || bus.o_cmd_len !== 8'h00) begin failures++; $display("FAIL reset_opc_len: got %h/%h expected 00/00", bus.o_cmd_opcode, bus.o_cmd_len); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        int e0;
        e0 = err_seen;
        bus.i_cmd_ready = 1'b1;
        send_byte(8'hAA);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL good_busy: got %b expected 1", bus.o_busy); end
        send_bytes({8'h10, 8'h02, 8'h5A, 8'hA5}, 4);
        checks++; if (bus.o_cmd_valid !== 1'b0) begin failures++; $display("FAIL good_early_valid: got %b expected 0", bus.o_cmd_valid); end
        send_byte(8'hED);
        checks++; if (bus.o_cmd_valid !== 1'b1) begin failures++; $display("FAIL good_valid: got %b expected 1", bus.o_cmd_valid); end
        checks++; if (bus.o_cmd_opcode !== 8'h10) begin failures++; $display("FAIL good_opcode: got %h expected 10", bus.o_cmd_opcode); end
        checks++; if (bus.o_cmd_len !== 8'h02) begin failures++; $display("FAIL good_len: got %h expected 02", bus.o_cmd_len); end
        checks++; if (bus.o_cmd_payload !== 64'h000000000000A55A) begin failures++; $display("FAIL good_payload: got %h expected A55A", bus.o_cmd_payload); end
        @(negedge clk);
        checks++; if (bus.o_cmd_valid !== 1'b0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL good_release: got valid=%b busy=%b expected 0/0", bus.o_cmd_valid, bus.o_busy); end
        // SYNC value inside the payload is plain data
        send_bytes({8'hAA, 8'h05, 8'h01, 8'hAA, 8'hAE}, 5);
        checks++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_payload !== 64'h00000000000000AA) begin failures++; $display("FAIL sync_as_data: got valid=%b payload=%h expected 1/AA", bus.o_cmd_valid, bus.o_cmd_payload); end
        repeat (2) @(negedge clk);
        checks++; if (err_seen !== e0) begin failures++; $display("FAIL good_no_err: got %0d errors expected 0", err_seen - e0); end
    endtask

    task automatic test_bad_checksum;
        bus.i_cmd_ready = 1'b1;
        send_bytes({8'hAA, 8'h10, 8'h02, 8'h5A, 8'hA5, 8'h00}, 6);
        checks++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd0) begin failures++; $display("FAIL chk_err: got err=%b code=%0d expected 1/0", bus.o_err, bus.o_err_code); end
        checks++; if (bus.o_cmd_valid !== 1'b0) begin failures++; $display("FAIL chk_valid: got %b expected 0", bus.o_cmd_valid); end
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_err !== 1'b0) begin failures++; $display("FAIL chk_after: got busy=%b err=%b expected 0/0", bus.o_busy, bus.o_err); end
        send_bytes({8'hAA, 8'h10, 8'h02, 8'h5A, 8'hA5, 8'hEF}, 6);
        checks++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd0 || bus.o_cmd_valid !== 1'b0) begin failures++; $display("FAIL chk_off_by_two: got err=%b code=%0d valid=%b expected 1/0/0", bus.o_err, bus.o_err_code, bus.o_cmd_valid); end
        @(negedge clk);
    endtask

    task automatic test_length;
        bus.i_cmd_ready = 1'b1;
        send_bytes({8'hAA, 8'h01, 8'h09}, 3);
        checks++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd1) begin failures++; $display("FAIL len_err: got err=%b code=%0d expected 1/1", bus.o_err, bus.o_err_code); end
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL len_busy: got %b expected 0", bus.o_busy); end
        send_bytes({8'hAA, 8'h03, 8'h08, 64'h0102030405060708, 8'h03}, 12);
        checks++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_len !== 8'h08) begin failures++; $display("FAIL len_max: got valid=%b len=%h expected 1/08", bus.o_cmd_valid, bus.o_cmd_len); end
        checks++; if (bus.o_cmd_payload !== 64'h0807060504030201) begin failures++; $display("FAIL len_max_payload: got %h expected 0807060504030201", bus.o_cmd_payload); end
        send_bytes({8'hAA, 8'h01, 8'h00, 8'h01}, 4);
        checks++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_len !== 8'h00) begin failures++; $display("FAIL len_zero: got valid=%b len=%h expected 1/00", bus.o_cmd_valid, bus.o_cmd_len); end
        checks++; if (bus.o_cmd_payload !== 64'h0) begin failures++; $display("FAIL len_zero_payload: got %h expected 0", bus.o_cmd_payload); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bus.i_cmd_ready = 1'b0;
        send_bytes({8'hAA, 8'h10, 8'h02, 8'h5A, 8'hA5, 8'hED}, 6);
        repeat (3) @(negedge clk);
        checks++; if (bus.o_cmd_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: got %b expected 1", bus.o_cmd_valid); end
        send_byte(8'h33);
        checks++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd2) begin failures++; $display("FAIL bp_ovf: got err=%b code=%0d expected 1/2", bus.o_err, bus.o_err_code); end
        checks++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_opcode !== 8'h10 || bus.o_cmd_len !== 8'h02 || bus.o_cmd_payload !== 64'hA55A) begin failures++; $display("FAIL bp_kept: got valid=%b opc=%h len=%h payload=%h expected 1/10/02/A55A", bus.o_cmd_valid, bus.o_cmd_opcode, bus.o_cmd_len, bus.o_cmd_payload); end
        bus.i_cmd_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_cmd_valid !== 1'b0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", bus.o_cmd_valid, bus.o_busy); end
        bus.i_cmd_ready = 1'b0;
        send_bytes({8'hAA, 8'h05, 8'h01, 8'hAA, 8'hAE}, 5);
        @(negedge clk);
        bus.i_rx_done   = 1'b1;
        bus.i_rx_byte   = 8'h44;
        bus.i_cmd_ready = 1'b1;
        @(negedge clk);
        bus.i_rx_done   = 1'b0;
        bus.i_cmd_ready = 1'b0;
        checks++; if (bus.o_cmd_valid !== 1'b0 || bus.o_err !== 1'b1 || bus.o_err_code !== 2'd2) begin failures++; $display("FAIL bp_same_cycle: got valid=%b err=%b code=%0d expected 0/1/2", bus.o_cmd_valid, bus.o_err, bus.o_err_code); end
        @(negedge clk);
    endtask

    task automatic test_noise;
        int e0;
        e0 = err_seen;
        send_bytes({8'h00, 8'hFF, 8'h55}, 3);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_cmd_valid !== 1'b0) begin failures++; $display("FAIL noise_idle: got busy=%b valid=%b expected 0/0", bus.o_busy, bus.o_cmd_valid); end
        repeat (2) @(negedge clk);
        checks++; if (err_seen !== e0) begin failures++; $display("FAIL noise_err: got %0d errors expected 0", err_seen - e0); end
    endtask

    task automatic test_reset_mid_frame;
        send_bytes({8'hAA, 8'h10, 8'h04, 8'h11, 8'h22}, 5);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy: got %b expected 1", bus.o_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_cmd_payload !== 64'h0) begin failures++; $display("FAIL rst_mid_clear: got busy=%b payload=%h expected 0/0", bus.o_busy, bus.o_cmd_payload); end
        rst_n = 1'b1;
        bus.i_cmd_ready = 1'b1;
        send_bytes({8'hAA, 8'h10, 8'h02, 8'h5A, 8'hA5, 8'hED}, 6);
        checks++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_payload !== 64'hA55A) begin failures++; $display("FAIL rst_mid_next: got valid=%b payload=%h expected 1/A55A", bus.o_cmd_valid, bus.o_cmd_payload); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_seen;
        bus.i_cmd_ready = 1'b0;
        send_bytes({8'hAA, 8'h10}, 2);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL tmo_busy_start: got %b expected 1", bus.o_busy); end
`ifdef UART_CMD_TIMEOUT_EN
        begin
            bit         found;
            int         waited;
            logic [1:0] code;
            found  = 1'b0;
            waited = 0;
            code   = 2'd0;
            for (int i = 0; i < 2 * TMO_CYCLES && !found; i++) begin
                @(negedge clk);
                waited = i + 1;
                if (bus.o_err === 1'b1) begin
                    found = 1'b1;
                    code  = bus.o_err_code;
                end
            end
            checks++; if (!found || code !== 2'd3) begin failures++; $display("FAIL tmo_err: got found=%0d code=%0d expected 1/3", found, code); end
            checks++; if (waited < int'(TMO_CYCLES) - 1 || waited > int'(TMO_CYCLES) + 1) begin failures++; $display("FAIL tmo_length: got %0d cycles expected %0d", waited, TMO_CYCLES); end
            @(negedge clk);
            checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL tmo_idle: got busy=%b expected 0", bus.o_busy); end
        end
`else
        repeat (TMO_CYCLES + 200) @(negedge clk);
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL tmo_off_busy: got %b expected 1", bus.o_busy); end
        checks++; if (err_seen !== e0) begin failures++; $display("FAIL tmo_off_err: got %0d errors expected 0", err_seen - e0); end
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_length();
        test_backpressure();
        test_noise();
        test_reset_mid_frame();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
